// File: rtl/arbiter_in_node_pkg.sv
// Shared encodings for the IN-node router: flit framing, download-stage status,
// destinations and the coherence command codes the decoder cares about.
package arbiter_in_node_pkg;

    localparam int FLIT_W = 16;
    localparam int CMD_W  = 5;

    localparam logic [1:0] CTRL_RSVD = 2'b00;
    localparam logic [1:0] CTRL_HEAD = 2'b01;
    localparam logic [1:0] CTRL_BODY = 2'b10;
    localparam logic [1:0] CTRL_TAIL = 2'b11;

    localparam logic [1:0] DL_IDLE = 2'b00;
    localparam logic [1:0] DL_BUSY = 2'b01;
    localparam logic [1:0] DL_RDY  = 2'b10;

    // Replies carry cmd[4]=1; requests carry cmd[4]=0.
    localparam logic [CMD_W-1:0] CMD_INSTREP   = 5'b10100;
    localparam logic [CMD_W-1:0] CMD_NACKREP   = 5'b10101;
    localparam logic [CMD_W-1:0] CMD_EXREP     = 5'b11001;
    localparam logic [CMD_W-1:0] CMD_C2CINVREP = 5'b11011;
    localparam logic [CMD_W-1:0] CMD_SCFLUREP  = 5'b11100;

    typedef enum logic [1:0] {
        DEST_NONE = 2'd0,
        DEST_IC   = 2'd1,
        DEST_DC   = 2'd2,
        DEST_MEM  = 2'd3
    } dest_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } route_state_e;

    function automatic logic is_request(input logic [CMD_W-1:0] cmd);
        return !cmd[CMD_W-1];
    endfunction

endpackage

// File: rtl/arbiter_in_node_in_cmd_decode.sv
// Head-flit command decoder: picks the download stage and flags packets that
// end on their head flit.
module in_cmd_decode
    import arbiter_in_node_pkg::*;
(
    input  logic [CMD_W-1:0] cmd,
    output dest_e            dest,
    output logic             single_flit
);

    always_comb begin
        dest = DEST_DC;
        if (is_request(cmd)) begin
            dest = DEST_MEM;
        end else if (cmd == CMD_INSTREP) begin
            dest = DEST_IC;
        end
    end

    assign single_flit = (cmd == CMD_NACKREP) || (cmd == CMD_SCFLUREP) ||
                         (cmd == CMD_C2CINVREP);

endmodule

// File: rtl/arbiter_in_node.sv
// IN-node router: steers flits from the IN FIFO to the ic/dc/mem download stages
// with zero-latency forwarding, dropping orphan and over-length traffic.
module arbiter_in_node
    import arbiter_in_node_pkg::*;
#(
    parameter int MAX_FLITS = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] IN_flit,
    input  logic              v_IN_flit,
    input  logic [1:0]        IN_flit_ctrl,
    output logic              IN_pop,
    input  logic [1:0]        ic_download_state,
    input  logic [1:0]        dc_download_state,
    input  logic [1:0]        mem_download_state,
    output logic [FLIT_W-1:0] OUT_flit,
    output logic [1:0]        OUT_flit_ctrl,
    output logic              v_flit_ic,
    output logic              v_flit_dc,
    output logic              v_flit_mem,
    output logic              err_orphan,
    output logic              err_len
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_FLITS);

    route_state_e state_q, state_n;
    dest_e        dest_q, dest_n;
    logic [3:0]   cnt_q, cnt_n;

    dest_e      head_dest;
    logic       head_single;
    logic [1:0] head_dest_state;
    dest_e      fwd_dest;
    logic       fwd_en;
    logic       set_orphan;
    logic       set_len;

    in_cmd_decode u_decode (
        .cmd         (IN_flit[9:5]),
        .dest        (head_dest),
        .single_flit (head_single)
    );

    always_comb begin
        case (head_dest)
            DEST_IC:  head_dest_state = ic_download_state;
            DEST_DC:  head_dest_state = dc_download_state;
            DEST_MEM: head_dest_state = mem_download_state;
            default:  head_dest_state = DL_BUSY;
        endcase
    end

    always_comb begin
        state_n    = state_q;
        dest_n     = dest_q;
        cnt_n      = cnt_q;
        IN_pop     = 1'b0;
        fwd_en     = 1'b0;
        fwd_dest   = dest_q;
        set_orphan = 1'b0;
        set_len    = 1'b0;
        if (!rst && v_IN_flit) begin
            case (state_q)
                ST_IDLE: begin
                    if (IN_flit_ctrl != CTRL_HEAD) begin
                        IN_pop     = 1'b1;
                        set_orphan = 1'b1;
                    end else if (head_dest_state == DL_IDLE) begin
                        IN_pop   = 1'b1;
                        fwd_en   = 1'b1;
                        fwd_dest = head_dest;
                        cnt_n    = 4'd1;
                        if (!head_single) begin
                            state_n = ST_FWD;
                            dest_n  = head_dest;
                        end
                    end
                end
                ST_FWD: begin
                    IN_pop = 1'b1;
                    // Body flits go out regardless of stage status: the stage stays busy until the tail.
                    if (cnt_q < MAX_CNT) begin
                        fwd_en = 1'b1;
                        cnt_n  = cnt_q + 4'd1;
                    end else begin
                        set_len = 1'b1;
                        state_n = ST_DROP;
                    end
                    if (IN_flit_ctrl == CTRL_TAIL) begin
                        state_n = ST_IDLE;
                        dest_n  = DEST_NONE;
                        cnt_n   = 4'd0;
                    end
                end
                ST_DROP: begin
                    IN_pop = 1'b1;
                    if (IN_flit_ctrl == CTRL_TAIL) begin
                        state_n = ST_IDLE;
                        dest_n  = DEST_NONE;
                        cnt_n   = 4'd0;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    dest_n  = DEST_NONE;
                    cnt_n   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dest_q     <= DEST_NONE;
            cnt_q      <= 4'd0;
            err_orphan <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            state_q    <= state_n;
            dest_q     <= dest_n;
            cnt_q      <= cnt_n;
            err_orphan <= err_orphan | set_orphan;
            err_len    <= err_len | set_len;
        end
    end

    assign OUT_flit      = IN_flit;
    assign OUT_flit_ctrl = IN_flit_ctrl;
    assign v_flit_ic     = fwd_en && (fwd_dest == DEST_IC);
    assign v_flit_dc     = fwd_en && (fwd_dest == DEST_DC);
    assign v_flit_mem    = fwd_en && (fwd_dest == DEST_MEM);

endmodule

// File: tb/tb_arbiter_in_node.sv
// Randomized and directed bench for arbiter_in_node against a packet-level model.
module tb_arbiter_in_node;

    typedef struct {
        logic [15:0] flit;
        logic [1:0]  ctrl;
    } flit_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] IN_flit = '0;
    logic        v_IN_flit = 1'b0;
    logic [1:0]  IN_flit_ctrl = 2'b00;
    logic        IN_pop;
    logic [1:0]  ic_st = 2'b00, dc_st = 2'b00, mem_st = 2'b00;
    logic [15:0] OUT_flit;
    logic [1:0]  OUT_flit_ctrl;
    logic        v_flit_ic, v_flit_dc, v_flit_mem, err_orphan, err_len;

    arbiter_in_node #(.MAX_FLITS(9)) dut (
        .clk(clk), .rst(rst), .IN_flit(IN_flit), .v_IN_flit(v_IN_flit),
        .IN_flit_ctrl(IN_flit_ctrl), .IN_pop(IN_pop),
        .ic_download_state(ic_st), .dc_download_state(dc_st), .mem_download_state(mem_st),
        .OUT_flit(OUT_flit), .OUT_flit_ctrl(OUT_flit_ctrl),
        .v_flit_ic(v_flit_ic), .v_flit_dc(v_flit_dc), .v_flit_mem(v_flit_mem),
        .err_orphan(err_orphan), .err_len(err_len)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    flit_t q[$];
    bit gate = 1'b1;
    bit popped = 1'b0;
    int tot_pop = 0, tot_stall = 0, tot_ic = 0, tot_dc = 0, tot_mem = 0;

    // Packet-level model: an open packet, its destination and how many flits it has consumed.
    bit m_open = 0;
    int m_dest = 0;
    int m_seen = 0;
    bit m_err_o = 0, m_err_l = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // 0 = ic, 1 = dc, 2 = mem
    function automatic int dest_of(input logic [4:0] cmd);
        if (cmd[4] == 1'b0) return 2;
        if (cmd == 5'b10100) return 0;
        return 1;
    endfunction

    function automatic bit single_of(input logic [4:0] cmd);
        return cmd == 5'b10101 || cmd == 5'b11100 || cmd == 5'b11011;
    endfunction

    initial begin
        forever begin
            logic [2:0] ev;
            logic [1:0] st [3];
            bit e_pop, s_o, s_l;
            @(negedge clk);
            ev = 3'b000; e_pop = 0; s_o = 0; s_l = 0;
            st[0] = ic_st; st[1] = dc_st; st[2] = mem_st;
            if (!rst && v_IN_flit) begin
                if (m_open) begin
                    e_pop = 1;
                    if (m_seen < 9) ev[m_dest] = 1'b1;
                    else s_l = 1;
                    m_seen++;
                    if (IN_flit_ctrl == 2'b11) m_open = 0;
                end else if (IN_flit_ctrl == 2'b01) begin
                    int d;
                    d = dest_of(IN_flit[9:5]);
                    if (st[d] == 2'b00) begin
                        e_pop = 1;
                        ev[d] = 1'b1;
                        if (!single_of(IN_flit[9:5])) begin
                            m_open = 1; m_dest = d; m_seen = 1;
                        end
                    end
                end else begin
                    e_pop = 1;
                    s_o = 1;
                end
            end
            check("outputs", {26'd0, IN_pop, v_flit_ic, v_flit_dc, v_flit_mem, err_orphan, err_len},
                  {26'd0, e_pop, ev[0], ev[1], ev[2], m_err_o, m_err_l});
            check("passthru", {14'd0, OUT_flit_ctrl, OUT_flit}, {14'd0, IN_flit_ctrl, IN_flit});
            popped = (IN_pop === 1'b1);
            if (IN_pop === 1'b1) tot_pop++;
            if (!rst && v_IN_flit && IN_pop !== 1'b1) tot_stall++;
            if (v_flit_ic === 1'b1) tot_ic++;
            if (v_flit_dc === 1'b1) tot_dc++;
            if (v_flit_mem === 1'b1) tot_mem++;
            if (rst) begin
                m_open = 0; m_seen = 0; m_err_o = 0; m_err_l = 0;
            end else begin
                m_err_o = m_err_o | s_o;
                m_err_l = m_err_l | s_l;
            end
        end
    end

    task automatic drive();
        v_IN_flit = (q.size() > 0) && gate;
        if (q.size() > 0) begin
            IN_flit = q[0].flit;
            IN_flit_ctrl = q[0].ctrl;
        end else begin
            IN_flit = 16'($urandom);
            IN_flit_ctrl = 2'($urandom);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (popped && q.size() > 0) void'(q.pop_front());
        drive();
    endtask

    task automatic push(input logic [1:0] ctrl, input logic [4:0] cmd);
        flit_t f;
        f.flit = 16'($urandom);
        f.flit[9:5] = cmd;
        f.ctrl = ctrl;
        q.push_back(f);
    endtask

    task automatic push_pkt(input logic [4:0] cmd, input int n_body);
        push(2'b01, cmd);
        for (int i = 0; i < n_body; i++) push(2'b10, 5'($urandom));
        push(2'b11, 5'($urandom));
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() > 0; i++) step();
        check("drain_timeout", q.size(), 0);
    endtask

    initial begin
        int s_pop, s_ic, s_dc, s_mem, s_stall;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset_err", {30'd0, err_orphan, err_len}, 0);

        // 1: exrep, 9 flits to dc
        s_pop = tot_pop; s_dc = tot_dc;
        push_pkt(5'b11001, 7);
        drain(30);
        check("t1_dc_pulses", tot_dc - s_dc, 9);
        check("t1_pops", tot_pop - s_pop, 9);

        // 2: nackrep single then instrep head
        s_ic = tot_ic; s_dc = tot_dc;
        push(2'b01, 5'b10101);
        push(2'b01, 5'b10100);
        push(2'b11, 5'b00000);
        drain(10);
        check("t2_dc", tot_dc - s_dc, 1);
        check("t2_ic", tot_ic - s_ic, 2);

        // 3: instrep stalls while ic is rdy
        s_stall = tot_stall; s_ic = tot_ic;
        ic_st = 2'b10;
        push(2'b01, 5'b10100);
        repeat (5) step();
        step();
        ic_st = 2'b00;
        check("t3_stalls", tot_stall - s_stall, 5);
        check("t3_no_ic", tot_ic - s_ic, 0);
        step();
        check("t3_ic", tot_ic - s_ic, 1);
        push(2'b11, 5'b00000);
        drain(10);

        // 4: orphan body
        s_pop = tot_pop; s_ic = tot_ic; s_dc = tot_dc; s_mem = tot_mem;
        push(2'b10, 5'b11001);
        drain(5);
        check("t4_orphan", {31'd0, err_orphan}, 1);
        check("t4_no_v", (tot_ic - s_ic) + (tot_dc - s_dc) + (tot_mem - s_mem), 0);
        repeat (3) step();
        check("t4_sticky", {31'd0, err_orphan}, 1);

        // 5: over-length request to mem
        s_pop = tot_pop; s_mem = tot_mem;
        push_pkt(5'b00011, 10);
        drain(30);
        check("t5_mem", tot_mem - s_mem, 9);
        check("t5_pops", tot_pop - s_pop, 12);
        check("t5_err_len", {31'd0, err_len}, 1);

        // 6: reset mid-packet
        s_pop = tot_pop; s_dc = tot_dc;
        push_pkt(5'b11001, 6);
        for (int i = 0; i < 20 && tot_pop - s_pop < 3; i++) step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("t6_dc_before", tot_dc - s_dc, 3);
        check("t6_err_clr", {30'd0, err_orphan, err_len}, 0);
        drain(20);
        check("t6_orphans", {31'd0, err_orphan}, 1);
        check("t6_pops", tot_pop - s_pop, 8);
        s_dc = tot_dc;
        push(2'b01, 5'b10101);
        drain(5);
        check("t6_next_head", tot_dc - s_dc, 1);

        // Random traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (q.size() < 4) begin
                int r;
                logic [4:0] cmds [6];
                cmds[0] = 5'b10100; cmds[1] = 5'b10101; cmds[2] = 5'b11100;
                cmds[3] = 5'b11011; cmds[4] = 5'b11001; cmds[5] = 5'($urandom);
                r = $urandom_range(0, 19);
                if (r == 0) push(2'b10, 5'($urandom));
                else if (r == 1) push(2'b00, 5'($urandom));
                else begin
                    logic [4:0] c;
                    c = cmds[$urandom_range(0, 5)];
                    if (single_of(c)) push(2'b01, c);
                    else push_pkt(c, $urandom_range(0, 11));
                end
            end
            gate = ($urandom_range(0, 3) != 0);
            step();
            ic_st  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 2));
            dc_st  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 2));
            mem_st = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 2));
            if (cyc == 2000) rst = 1'b1;
            if (cyc == 2002) rst = 1'b0;
        end
        gate = 1'b1;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
